// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage with the IF/ID pipeline register.
//   Keeps the fetch PC, issues one word read per cycle to a synchronous
//   instruction memory (1-cycle latency), absorbs decode stalls with a
//   one-entry skid buffer and takes branch/jump redirects from execute.
// Ports:
//   clk, rst             clock (rising edge), async active-high reset
//   stall_d, flush_d     hold / bubble requests from the hazard unit
//   pc_src_e, pc_target_e redirect from execute (highest priority)
//   imem_en, imem_addr   memory read request, address = fetch PC
//   imem_rdata           data for the request enabled last cycle
//   instr_d, opcode_d    IF/ID instruction and its 5-bit opcode field
//   pc_d, pc_plus_d      PC of instr_d and PC + PC_STEP (registered)
//   valid_d              IF/ID holds a real instruction
module fetch_stage #(
  parameter int                 PC_W         = 32,
  parameter int                 INSTR_W      = 32,
  parameter logic [PC_W-1:0]    PC_STEP      = PC_W'(4),
  parameter logic [PC_W-1:0]    PC_RESET     = '0,
  parameter logic [INSTR_W-1:0] BUBBLE_INSTR = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall_d,
  input  logic               flush_d,
  input  logic               pc_src_e,
  input  logic [PC_W-1:0]    pc_target_e,
  output logic               imem_en,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr_d,
  output logic [4:0]         opcode_d,
  output logic [PC_W-1:0]    pc_d,
  output logic [PC_W-1:0]    pc_plus_d,
  output logic               valid_d
);

  typedef enum logic [1:0] {BOOT, RUN, STALL} state_t;

  state_t              state_q, state_d;
  logic [PC_W-1:0]     pc_f_q, pc_f_d;
  logic [PC_W-1:0]     req_pc_q, req_pc_d;
  logic                req_valid_q, req_valid_d;
  logic [INSTR_W-1:0]  skid_instr_q, skid_instr_d;
  logic [PC_W-1:0]     skid_pc_q, skid_pc_d;
  logic                skid_valid_q, skid_valid_d;
  // Set on a redirect edge: the following BOOT cycle is a dead cycle so the
  // redirect penalty is a fixed two bubbles after the flushed slot.
  logic                redir_q, redir_d;
  logic [INSTR_W-1:0]  ifid_instr_q, ifid_instr_d;
  logic [PC_W-1:0]     ifid_pc_q, ifid_pc_d;
  logic [PC_W-1:0]     ifid_pcp_q, ifid_pcp_d;
  logic                ifid_vld_q, ifid_vld_d;

  // State register (FSM plus datapath registers)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= BOOT;
      pc_f_q       <= PC_RESET;
      req_pc_q     <= '0;
      req_valid_q  <= 1'b0;
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
      skid_valid_q <= 1'b0;
      redir_q      <= 1'b0;
      ifid_instr_q <= BUBBLE_INSTR;
      ifid_pc_q    <= '0;
      ifid_pcp_q   <= '0;
      ifid_vld_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_f_q       <= pc_f_d;
      req_pc_q     <= req_pc_d;
      req_valid_q  <= req_valid_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
      skid_valid_q <= skid_valid_d;
      redir_q      <= redir_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_pcp_q   <= ifid_pcp_d;
      ifid_vld_q   <= ifid_vld_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d      = state_q;
    pc_f_d       = pc_f_q;
    req_pc_d     = req_pc_q;
    req_valid_d  = req_valid_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    skid_valid_d = skid_valid_q;
    redir_d      = redir_q;
    ifid_instr_d = ifid_instr_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_pcp_d   = ifid_pcp_q;
    ifid_vld_d   = ifid_vld_q;

    if (pc_src_e) begin
      pc_f_d       = pc_target_e;
      req_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
      redir_d      = 1'b1;
      ifid_vld_d   = 1'b0;
      ifid_instr_d = BUBBLE_INSTR;
      state_d      = BOOT;
    end else begin
      unique case (state_q)
        BOOT: begin
          if (redir_q) begin
            redir_d = 1'b0;
          end else if (!stall_d) begin
            req_pc_d    = pc_f_q;
            req_valid_d = 1'b1;
            pc_f_d      = pc_f_q + PC_STEP;
            state_d     = RUN;
          end
        end
        RUN, STALL: begin
          if (stall_d) begin
            // Park the in-flight read: memory data is only valid this cycle.
            if (req_valid_q && !skid_valid_q) begin
              skid_instr_d = imem_rdata;
              skid_pc_d    = req_pc_q;
              skid_valid_d = 1'b1;
              req_valid_d  = 1'b0;
            end
            state_d = STALL;
          end else begin
            // skid_valid_q is only ever set in STALL, so RUN takes the req path.
            if (skid_valid_q) begin
              ifid_instr_d = skid_instr_q;
              ifid_pc_d    = skid_pc_q;
              ifid_pcp_d   = skid_pc_q + PC_STEP;
              ifid_vld_d   = 1'b1;
            end else if (req_valid_q) begin
              ifid_instr_d = imem_rdata;
              ifid_pc_d    = req_pc_q;
              ifid_pcp_d   = req_pc_q + PC_STEP;
              ifid_vld_d   = 1'b1;
            end else begin
              ifid_instr_d = BUBBLE_INSTR;
              ifid_vld_d   = 1'b0;
            end
            skid_valid_d = 1'b0;
            req_pc_d     = pc_f_q;
            req_valid_d  = 1'b1;
            pc_f_d       = pc_f_q + PC_STEP;
            state_d      = RUN;
          end
        end
        default: state_d = BOOT;
      endcase
      // Flush only squashes IF/ID; fetch state advances as if unflushed.
      if (flush_d) begin
        ifid_instr_d = BUBBLE_INSTR;
        ifid_vld_d   = 1'b0;
        ifid_pc_d    = ifid_pc_q;
        ifid_pcp_d   = ifid_pcp_q;
      end
    end
  end

  // Output logic
  always_comb begin
    imem_en = !rst && !pc_src_e && !stall_d && !((state_q == BOOT) && redir_q);
  end

  assign imem_addr = pc_f_q;
  assign instr_d   = ifid_instr_q;
  assign opcode_d  = ifid_instr_q[INSTR_W-1 -: 5];
  assign pc_d      = ifid_pc_q;
  assign pc_plus_d = ifid_pcp_q;
  assign valid_d   = ifid_vld_q;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
  logic        clk = 1'b0;
  logic        rst, rst2;
  logic        stall_d, flush_d, pc_src_e;
  logic [31:0] pc_target_e;
  logic        imem_en, imem_en2;
  logic [31:0] imem_addr, imem_addr2, imem_rdata, imem_rdata2;
  logic [31:0] instr_d, instr_d2, pc_d, pc_d2, pc_plus_d, pc_plus_d2;
  logic [4:0]  opcode_d, opcode_d2;
  logic        valid_d, valid_d2;
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk(clk), .rst(rst), .stall_d(stall_d), .flush_d(flush_d),
    .pc_src_e(pc_src_e), .pc_target_e(pc_target_e),
    .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .instr_d(instr_d), .opcode_d(opcode_d), .pc_d(pc_d),
    .pc_plus_d(pc_plus_d), .valid_d(valid_d));

  fetch_stage #(.PC_RESET(32'hFFFF_FFF8)) dut2 (
    .clk(clk), .rst(rst2), .stall_d(1'b0), .flush_d(1'b0),
    .pc_src_e(1'b0), .pc_target_e(32'h0),
    .imem_en(imem_en2), .imem_addr(imem_addr2), .imem_rdata(imem_rdata2),
    .instr_d(instr_d2), .opcode_d(opcode_d2), .pc_d(pc_d2),
    .pc_plus_d(pc_plus_d2), .valid_d(valid_d2));

  // Synchronous memory: word at N is 0x0800_0000+N; garbage when not enabled.
  always @(posedge clk) begin
    imem_rdata  <= imem_en  ? 32'h0800_0000 + imem_addr  : 32'hDEAD_BEEF;
    imem_rdata2 <= imem_en2 ? 32'h0800_0000 + imem_addr2 : 32'hDEAD_BEEF;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; rst2 = 1'b1; stall_d = 1'b0; flush_d = 1'b0;
    pc_src_e = 1'b0; pc_target_e = 32'h0;
    tick(); tick();
    // Reset state
    chk("rst_valid", {31'b0, valid_d}, 32'd0);
    chk("rst_instr", instr_d, 32'h0);
    chk("rst_pc", pc_d, 32'h0);
    chk("rst_pcplus", pc_plus_d, 32'h0);
    chk("rst_en", {31'b0, imem_en}, 32'd0);
    rst = 1'b0;
    #1 chk("boot_en", {31'b0, imem_en}, 32'd1);
    // 1: sequential flow
    tick(); chk("e1_valid", {31'b0, valid_d}, 32'd0);
    tick(); chk("e2_valid", {31'b0, valid_d}, 32'd1);
    chk("e2_pc", pc_d, 32'h0);
    chk("e2_pcplus", pc_plus_d, 32'h4);
    chk("e2_opcode", {27'b0, opcode_d}, 32'd1);
    chk("e2_instr", instr_d, 32'h0800_0000);
    tick(); chk("seq_pc4", pc_d, 32'h4);
    tick(); chk("seq_pc8", pc_d, 32'h8);
    // 2: stall 3 cycles at pc_d=8
    stall_d = 1'b1;
    #1 chk("stall_en", {31'b0, imem_en}, 32'd0);
    tick(); chk("stall1_pc", pc_d, 32'h8);
    tick(); chk("stall2_pc", pc_d, 32'h8);
    chk("stall2_en", {31'b0, imem_en}, 32'd0);
    tick(); chk("stall3_pc", pc_d, 32'h8);
    chk("stall3_instr", instr_d, 32'h0800_0008);
    stall_d = 1'b0;
    #1 chk("unstall_en", {31'b0, imem_en}, 32'd1);
    tick(); chk("unstall_pc12", pc_d, 32'hC);
    chk("unstall_instr", instr_d, 32'h0800_000C);
    chk("unstall_valid", {31'b0, valid_d}, 32'd1);
    tick(); chk("unstall_pc16", pc_d, 32'h10);
    // 5: flush one cycle at pc_d=16
    flush_d = 1'b1;
    tick(); chk("flush_valid", {31'b0, valid_d}, 32'd0);
    chk("flush_instr", instr_d, 32'h0);
    chk("flush_opcode", {27'b0, opcode_d}, 32'd0);
    chk("flush_pchold", pc_d, 32'h10);
    flush_d = 1'b0;
    tick(); chk("postflush_pc", pc_d, 32'h18);
    chk("postflush_valid", {31'b0, valid_d}, 32'd1);
    // 3: redirect to 0x40
    pc_src_e = 1'b1; pc_target_e = 32'h40;
    #1 chk("redir_en", {31'b0, imem_en}, 32'd0);
    tick(); chk("redir_b0", {31'b0, valid_d}, 32'd0);
    pc_src_e = 1'b0;
    tick(); chk("redir_b1", {31'b0, valid_d}, 32'd0);
    tick(); chk("redir_b2", {31'b0, valid_d}, 32'd0);
    tick(); chk("redir_valid", {31'b0, valid_d}, 32'd1);
    chk("redir_pc", pc_d, 32'h40);
    chk("redir_pcplus", pc_plus_d, 32'h44);
    chk("redir_instr", instr_d, 32'h0800_0040);
    tick(); chk("redir_next", pc_d, 32'h44);
    // 4: redirect with stall, skid loaded beforehand
    stall_d = 1'b1;
    tick();
    pc_src_e = 1'b1; pc_target_e = 32'h80;
    #1 chk("rs_en", {31'b0, imem_en}, 32'd0);
    tick(); chk("rs_b0", {31'b0, valid_d}, 32'd0);
    pc_src_e = 1'b0; stall_d = 1'b0;
    tick(); chk("rs_b1", {31'b0, valid_d}, 32'd0);
    tick(); chk("rs_b2", {31'b0, valid_d}, 32'd0);
    tick(); chk("rs_valid", {31'b0, valid_d}, 32'd1);
    chk("rs_pc", pc_d, 32'h80);
    // flush + stall: bubble, PC holds, stalled instruction survives
    stall_d = 1'b1; flush_d = 1'b1;
    tick(); chk("fs_valid", {31'b0, valid_d}, 32'd0);
    stall_d = 1'b0; flush_d = 1'b0;
    tick(); chk("fs_pc", pc_d, 32'h84);
    chk("fs_instr", instr_d, 32'h0800_0084);
    // 6: wraparound on second instance
    rst2 = 1'b0;
    tick(); chk("w_boot", {31'b0, valid_d2}, 32'd0);
    tick(); chk("w_pc0", pc_d2, 32'hFFFF_FFF8);
    chk("w_pcp0", pc_plus_d2, 32'hFFFF_FFFC);
    tick(); chk("w_pc1", pc_d2, 32'hFFFF_FFFC);
    chk("w_pcp1", pc_plus_d2, 32'h0);
    tick(); chk("w_pc2", pc_d2, 32'h0);
    chk("w_valid2", {31'b0, valid_d2}, 32'd1);
    rst2 = 1'b1;
    #1 chk("w_rst_valid", {31'b0, valid_d2}, 32'd0);
    chk("w_rst_en", {31'b0, imem_en2}, 32'd0);
    tick();
    rst2 = 1'b0;
    tick(); chk("w_re_b", {31'b0, valid_d2}, 32'd0);
    tick(); chk("w_re_pc", pc_d2, 32'hFFFF_FFF8);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
